// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: control FSM state encodings and the op field.
package fetch_unit_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        ADD    = 4'd2,
        PC     = 4'd3,
        JL1    = 4'd4,
        JL2    = 4'd5
    } ctrl_state_e;

    localparam int OP_W = 3;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_BUSY = 1'b1
    } req_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: req/addr held until a one-cycle ack returns rdata.
interface fetch_unit_if #(
    parameter int PC_W = 8,
    parameter int IW   = 8
);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            ack;
    logic [IW-1:0]   rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit_queue.sv
// Two-deep FIFO of prefetched {addr, instr} entries; flush wins over push/pop.
module fetch_queue #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: prefetches into a 2-entry queue, loads ir/pc in FETCH, redirects on JL2.
//  req_cur  | meaning
//  REQ_IDLE | no read outstanding; may issue a read of fpc
//  REQ_BUSY | read outstanding at imem.addr, waiting for ack
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      state,
    input  logic [PC_W-1:0] jump_target,
    fetch_unit_if.master    imem,
    output logic [IW-1:0]   ir,
    output logic [OP_W-1:0] op,
    output logic [PC_W-1:0] pc,
    output logic            stall
);
    localparam logic [PC_W-1:0] PC_ONE = 1;

    req_state_e        req_cur;
    req_state_e        req_nxt;
    logic [PC_W-1:0]   fpc;
    logic [PC_W-1:0]   addr_q;
    logic              discard;
    logic [1:0]        q_count;
    logic [PC_W+IW-1:0] q_dout;
    logic              redirect;
    logic              fetch_st;
    logic              acked;
    logic              push;
    logic              pop;
    logic              issue;

    assign redirect = (state == JL2);
    assign fetch_st = (state == FETCH);
    assign acked    = (req_cur == REQ_BUSY) && imem.ack;
    // Data returning for a request that a jump has already overtaken is dropped.
    assign push     = acked && !discard && !redirect;
    assign pop      = fetch_st && (q_count != 2'd0);
    assign issue    = (req_cur == REQ_IDLE) && (q_count < 2'd2) && !redirect;
    assign stall    = fetch_st && (q_count == 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) req_cur <= REQ_IDLE;
        else      req_cur <= req_nxt;
    end

    always_comb begin
        req_nxt = req_cur;
        case (req_cur)
            REQ_IDLE: if (issue)    req_nxt = REQ_BUSY;
            REQ_BUSY: if (imem.ack) req_nxt = REQ_IDLE;
            default:                req_nxt = REQ_IDLE;
        endcase
    end

    assign imem.req  = (req_cur == REQ_BUSY);
    assign imem.addr = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            fpc     <= '0;
            discard <= 1'b0;
        end else begin
            if (issue) addr_q <= fpc;
            if (redirect)  fpc <= jump_target;
            else if (push) fpc <= fpc + PC_ONE;
            // An un-acked read outstanding across a jump must not land in the queue.
            if (acked)                                 discard <= 1'b0;
            else if (redirect && req_cur == REQ_BUSY)  discard <= 1'b1;
        end
    end

    fetch_queue #(.W(PC_W + IW)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({imem.addr, imem.rdata}),
        .dout  (q_dout),
        .count (q_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir <= '0;
            pc <= '0;
        end else if (pop) begin
            ir <= q_dout[IW-1:0];
            pc <= q_dout[PC_W+IW-1:IW];
        end
    end

    assign op = ir[IW-1 -: OP_W];
endmodule
